// File: rtl/divisor_seq_if.sv
// Start/done handshake bundle shared by the divider and its controlling FSM.
// The requester holds start until it has consumed the result flagged by done.
interface divisor_seq_if #(
  parameter int unsigned N = 4
);

  logic             start;
  logic [2*N-1:0]   D_in;
  logic [N-1:0]     V_in;
  logic             done;
  logic [N-1:0]     Q_out;
  logic [N-1:0]     R_out;
  logic             ovf;

  modport master (
    output start,
    output D_in,
    output V_in,
    input  done,
    input  Q_out,
    input  R_out,
    input  ovf
  );

  modport slave (
    input  start,
    input  D_in,
    input  V_in,
    output done,
    output Q_out,
    output R_out,
    output ovf
  );

endinterface

// File: rtl/divisor_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient
// and remainder, one quotient bit per clock, start/done handshake.
module divisor_seq #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  divisor_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q;
  logic [N:0]     a_q;
  logic [N-1:0]   q_q;
  logic [N-1:0]   b_q;
  logic [CW-1:0]  cnt_q;
  logic           done_q;
  logic           ovf_q;
  logic [N-1:0]   quo_q;
  logic [N-1:0]   rem_q;

  logic [N:0]     a_sh;
  logic           fit;
  logic           ovf_hit;
  logic [N:0]     a_d;
  logic [N-1:0]   q_d;

  // One restoring step. The high dividend half is still in A on the first CALC
  // edge, so A >= B there is exactly the quotient-overflow (or zero-divisor) case.
  always_comb begin
    a_sh    = {a_q[N-1:0], q_q[N-1]};
    fit     = (a_sh >= {1'b0, b_q});
    a_d     = fit ? (a_sh - {1'b0, b_q}) : a_sh;
    q_d     = (q_q << 1) | N'(fit);
    ovf_hit = (cnt_q == CW'(N)) && (a_q >= {1'b0, b_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= {1'b0, bus.D_in[2*N-1:N]};
            q_q     <= bus.D_in[N-1:0];
            b_q     <= bus.V_in;
            cnt_q   <= CW'(N);
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= CALC;
          end
        end

        CALC: begin
          if (ovf_hit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            ovf_q   <= 1'b1;
            quo_q   <= '0;
            rem_q   <= '0;
          end else begin
            a_q   <= a_d;
            q_q   <= q_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quo_q   <= q_d;
              rem_q   <= a_d[N-1:0];
            end
          end
        end

        DONE: begin
          // A held start never retriggers: it must be seen low before IDLE.
          if (!bus.start) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.done  = done_q;
  assign bus.ovf   = ovf_q;
  assign bus.Q_out = quo_q;
  assign bus.R_out = rem_q;

endmodule

// File: doc/divisor_seq.md
Name: divisor_seq

Overview:
Sequential restoring divider. It is the inverse of the team's shift-add multiplier: it takes a 2N-bit dividend (the multiplier's product width) and an N-bit divisor, and returns an N-bit quotient and an N-bit remainder. It uses the same start/done handshake as the multiplier, so control FSMs can drive both blocks interchangeably. One quotient bit is produced per clock.

Parameters:
N, 4, operand width; dividend is 2N bits, divisor, quotient and remainder are N bits.

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
done  output  1  result valid; held high in DONE
D_in  input  2N  dividend, sampled on the start edge
V_in  input  N  divisor, sampled on the start edge
Q_out  output  N  quotient
R_out  output  N  remainder
ovf  output  1  overflow or divide-by-zero flag; valid when done=1

Behaviour:
- Reset: when rst=1 at a rising edge, state goes to IDLE and done, ovf, Q_out and R_out all become 0. Reset overrides start and aborts any operation in progress.
- Internal registers: A (N+1 bits, partial remainder), Q (N bits), B (N bits, divisor), cnt (counts 0..N, clog2(N+1) bits).
- FSM states: IDLE, CALC, DONE.
- IDLE, start=0: hold all registers; outputs keep the last result.
- IDLE, start=1 (call this edge k):
  - load A={1'b0, D_in[2N-1:N]}, Q=D_in[N-1:0], B=V_in, cnt=N; clear done and ovf.
  - if D_in[2N-1:N] >= V_in (quotient overflow; covers V_in=0): go to DONE with ovf=1, Q_out=0, R_out=0.
  - otherwise go to CALC.
- CALC, once per edge:
  - shift {A,Q} left by 1; the vacated Q LSB is 0.
  - if shifted A >= {1'b0,B}: A = A - B and Q[0] = 1.
  - decrement cnt.
  - on the edge where cnt goes 1 to 0: go to DONE, Q_out=Q (updated value), R_out=A[N-1:0].
- Latency: in the normal case done=1 after edge k+N (N CALC edges). In the overflow case done=1 after edge k+1.
- DONE: done=1 and outputs stable while start=1. When start=0 at an edge, go to IDLE; done drops to 0 and Q_out, R_out, ovf are held.
- A start still held high from the previous operation does not retrigger; a new operation needs start=0 for at least one edge.
- D_in and V_in changes during CALC or DONE are ignored.
- Q_out and R_out change only on CALC-to-DONE, on the overflow transition, and on reset.
- A is N+1 bits so the shifted value cannot lose its MSB. Invariant on exit: R_out < V_in.
- Result identity (no overflow): D_in = Q_out*V_in + R_out.

Test Plan:
1. N=4, D_in=8'h23 (35), V_in=4'h5, start held high -> done rises 4 edges after the start edge; Q_out=4'h7, R_out=4'h0, ovf=0.
2. D_in=8'h64 (100), V_in=4'h9 -> Q_out=4'hB, R_out=4'h1, ovf=0. Then D_in=8'hEF, V_in=4'hF -> Q_out=4'hF, R_out=4'hE, ovf=0 (max quotient).
3. D_in=8'h50, V_in=4'h5 -> done 1 edge after start, ovf=1, Q_out=0, R_out=0. Also D_in=8'h12, V_in=4'h0 -> ovf=1.
4. Handshake: keep start=1 for 10 extra cycles after done -> done stays 1, no recompute. Drop start -> done=0 next edge, Q_out/R_out held. Raise start with D_in=8'h3F, V_in=4'h7 -> Q_out=4'h9, R_out=4'h0.
5. Reset mid-operation: start 8'h23/4'h5, assert rst after 2 CALC edges -> done=0, Q_out=0, R_out=0, ovf=0 at that edge. Restart -> Q_out=7, R_out=0 after 4 edges.
6. Scoreboard sweep: all D_in with D_in[7:4] < V_in, V_in=1..15 -> Q_out and R_out match D_in/V_in and D_in%V_in; done latency always 4 edges.
